apb_master_n: RTL and testbench

Parametrised APB4 bridge master. It sits between the RV32I core's data-memory port and N peripheral slaves. It turns one-shot internal requests into APB SETUP/ACCESS transfers, decodes a regular address map into one-hot PSEL, and returns read data and a per-transfer error flag. Compared with the fixed five-slave bridge, it adds PSTRB, PSLVERR propagation, a decode-error response for unmapped addresses, and an optional access watchdog.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_master_n_if.sv | 44 ++++
 rtl/apb_addr_decoder.sv | 36 +++
 rtl/apb_master_n.sv | 141 ++++++++++++++
 tb/tb_apb_master_n.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the parametrised APB4 bridge master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } apb_state_e;

    localparam logic [31:0] APB_BASE_ADDR = 32'h1000_0000;
    localparam int          APB_SLOT_BITS = 12;

    // Width of a slave index; never narrower than one bit so a single-slave
    // build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_n_if.sv
// Bundle of the request side and the APB side of the bridge.
// Latency: n/a (wires only).
// Backpressure: none here; the bridge itself stalls on PREADY.
// Ports: request (transfer/write/addr/wdata/strb -> ready/rdata/error) and
// APB (PADDR/PWRITE/PENABLE/PWDATA/PSTRB/PSEL -> PRDATA/PREADY/PSLVERR).
interface apb_master_n_if #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) ();
    // APB side
    logic [ADDR_W-1:0]            PADDR;
    logic                         PWRITE;
    logic                         PENABLE;
    logic [DATA_W-1:0]            PWDATA;
    logic [DATA_W/8-1:0]          PSTRB;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;
    // Request side
    logic                         transfer;
    logic                         write;
    logic [ADDR_W-1:0]            addr;
    logic [DATA_W-1:0]            wdata;
    logic [DATA_W/8-1:0]          strb;
    logic                         ready;
    logic [DATA_W-1:0]            rdata;
    logic                         error;

    modport master (
        output PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL,
        input  PRDATA, PREADY, PSLVERR,
        input  transfer, write, addr, wdata, strb,
        output ready, rdata, error
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL,
        output PRDATA, PREADY, PSLVERR,
        output transfer, write, addr, wdata, strb,
        input  ready, rdata, error
    );
endinterface

// File: rtl/apb_addr_decoder.sv
// Regular address map decoder: slave i owns [BASE + i*2^SLOT_BITS, +2^SLOT_BITS).
// Latency: combinational.
// Backpressure: none; en low forces hit/idx/sel to zero.
// Ports: addr, en in; hit, idx (binary), sel (one-hot) out.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 5,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(APB_BASE_ADDR),
    parameter int                SLOT_BITS  = APB_SLOT_BITS
) (
    input  logic [ADDR_W-1:0]                addr,
    input  logic                             en,
    output logic                             hit,
    output logic [idx_width(NUM_SLAVES)-1:0] idx,
    output logic [NUM_SLAVES-1:0]            sel
);
    localparam int IDX_W = idx_width(NUM_SLAVES);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] slot;

    always_comb begin
        // Unsigned wrap below BASE_ADDR is caught by the explicit compare.
        offset = addr - BASE_ADDR;
        slot   = offset >> SLOT_BITS;
        hit    = en && (addr >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLAVES));
        idx    = '0;
        sel    = '0;
        if (hit) begin
            idx = slot[IDX_W-1:0];
            sel = NUM_SLAVES'(1) << idx;
        end
    end
endmodule

// File: rtl/apb_master_n.sv
// APB4 bridge master: one-shot requests -> SETUP/ACCESS on one of N slaves.
// Latency: mapped ready at cycle 2+W after accept, unmapped ready at cycle 1.
// Backpressure: ACCESS stalls on PREADY; transfer only sampled in IDLE.
// Ports: PCLK, PRESET (async, active-high), bus (apb_master_n_if.master).
// Optional: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
module apb_master_n
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 5,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(APB_BASE_ADDR),
    parameter int                SLOT_BITS  = APB_SLOT_BITS,
    parameter int                TIMEOUT    = 255
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_master_n_if.master  bus
);
    localparam int IDX_W = idx_width(NUM_SLAVES);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
        $error("NUM_SLAVES must be 1..16");
    end
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    apb_state_e          state;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [DATA_W/8-1:0] pstrb_q;
    logic                pwrite_q;

    logic                  live_hit;
    logic [IDX_W-1:0]      live_idx;
    logic [NUM_SLAVES-1:0] live_sel;
    logic                  cap_hit;
    logic [IDX_W-1:0]      cap_idx;
    logic [NUM_SLAVES-1:0] cap_sel;
    logic                  unused_dec;

    logic              sel_rdy;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              acc_done;
    logic              timeout_hit;

    // Live address: only decides SETUP vs DECERR at accept time.
    apb_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE_ADDR),   .SLOT_BITS(SLOT_BITS)
    ) u_dec_live (
        .addr(bus.addr), .en(state == IDLE),
        .hit(live_hit),  .idx(live_idx), .sel(live_sel)
    );

    // Captured address: drives PSEL and the response mux while a transfer
    // is on the bus; en drops PSEL as soon as the FSM leaves SETUP/ACCESS.
    apb_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE_ADDR),   .SLOT_BITS(SLOT_BITS)
    ) u_dec_cap (
        .addr(paddr_q), .en((state == SETUP) || (state == ACCESS)),
        .hit(cap_hit),  .idx(cap_idx), .sel(cap_sel)
    );

    assign unused_dec = ^{live_idx, live_sel};

    assign sel_rdy   = cap_hit & bus.PREADY[cap_idx];
    assign sel_err   = cap_hit & bus.PSLVERR[cap_idx];
    assign sel_rdata = bus.PRDATA[int'(cap_idx)*DATA_W +: DATA_W];

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] acc_cnt;
`endif

    always_comb begin
        acc_done    = (state == ACCESS) && sel_rdy;
        timeout_hit = 1'b0;
`ifdef APB_TIMEOUT_EN
        // A PREADY in the timeout cycle still completes normally.
        timeout_hit = (state == ACCESS) && !sel_rdy && (acc_cnt == CNT_W'(TIMEOUT));
`endif
    end

    assign bus.ready   = acc_done | timeout_hit | (state == DECERR);
    assign bus.error   = (acc_done & sel_err) | timeout_hit | (state == DECERR);
    assign bus.rdata   = (acc_done && !pwrite_q) ? sel_rdata : '0;

    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PSEL    = cap_sel;
    assign bus.PENABLE = (state == ACCESS);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pwrite_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            acc_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.transfer) begin
                        paddr_q  <= bus.addr;
                        pwdata_q <= bus.wdata;
                        pwrite_q <= bus.write;
                        pstrb_q  <= bus.write ? bus.strb : '0;
                        state    <= live_hit ? SETUP : DECERR;
`ifdef APB_TIMEOUT_EN
                        acc_cnt  <= '0;
`endif
                    end
                end
                SETUP:   state <= ACCESS;
                ACCESS: begin
                    if (acc_done || timeout_hit) begin
                        state <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    // Never wraps: ACCESS is left once the count hits TIMEOUT.
                    acc_cnt <= acc_cnt + 1'b1;
`endif
                end
                DECERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_n.sv
// Self-checking bench for apb_master_n (5 slaves, default address map).
// Latency: n/a.
// Backpressure: PREADY of the addressed slave is driven per scenario.
module tb_apb_master_n;
    localparam int NS = 5;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic PCLK;
    logic PRESET;
    int   errors = 0;
    int   checks = 0;

    apb_master_n_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_n #(
        .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32),
        .BASE_ADDR(BASE), .SLOT_BITS(12), .TIMEOUT(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        int          w;
        logic        slverr;
        logic [31:0] rd;
        int          lat;
        logic        err;
        logic [31:0] erd;
        logic [4:0]  psel;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transfer starting at posedge+1 of its accept cycle (cycle 0).
    // Returns at posedge+1 of the cycle after the expected ready.
    task automatic run(input string nm, input vec_t v);
        int          tgt;
        int          got;
        int          bad;
        logic [31:0] got_rd;
        logic        got_err;
        logic [4:0]  psel_e;
        logic        pen_e;
        tgt = -1;
        got = -1;
        bad = 0;
        got_rd = 'x;
        got_err = 1'bx;
        for (int s = 0; s < NS; s++) if (v.psel[s]) tgt = s;
        for (int c = 0; c <= v.lat; c++) begin
            if (c == 0) begin
                bus.transfer = 1'b1;
                bus.write = v.wr;
                bus.addr  = v.a;
                bus.wdata = v.wd;
                bus.strb  = v.st;
            end else begin
                // Requests while busy must be ignored.
                bus.transfer = 1'($urandom_range(0, 1));
                bus.write = 1'($urandom_range(0, 1));
                bus.addr  = $urandom;
                bus.wdata = $urandom;
                bus.strb  = 4'($urandom);
            end
            for (int s = 0; s < NS; s++) begin
                bus.PRDATA[s*32 +: 32] = (s == tgt) ? v.rd : $urandom;
                bus.PREADY[s]  = (s == tgt) ? (c >= 2 + v.w) : 1'($urandom_range(0, 1));
                bus.PSLVERR[s] = (s == tgt) ? v.slverr : 1'($urandom_range(0, 1));
            end
            #4;
            psel_e = (c >= 1) ? v.psel : 5'b0;
            pen_e  = (v.psel != 0) && (c >= 2);
            if (bus.PSEL !== psel_e || bus.PENABLE !== pen_e) bad++;
            if (bus.ready === 1'b1) begin
                if (got < 0) begin
                    got = c;
                    got_rd = bus.rdata;
                    got_err = bus.error;
                end
            end else if (bus.rdata !== 32'h0 || bus.error !== 1'b0) begin
                bad++;
            end
            if (c == v.lat) begin
                chk({nm, ".paddr"},  bus.PADDR, v.a);
                chk({nm, ".pwrite"}, bus.PWRITE, v.wr);
                chk({nm, ".pwdata"}, bus.PWDATA, v.wd);
                chk({nm, ".pstrb"},  bus.PSTRB, v.wr ? v.st : 4'h0);
            end
            @(posedge PCLK);
            #1;
        end
        chk({nm, ".ready_cycle"}, 64'(got), 64'(v.lat));
        chk({nm, ".rdata"}, got_rd, v.erd);
        chk({nm, ".error"}, got_err, v.err);
        chk({nm, ".bus_seq_errs"}, 64'(bad), 64'd0);
    endtask

    // Reference: plain address-map arithmetic on the request.
    function automatic vec_t model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] st, input int w, input logic slverr,
                                   input logic [31:0] rd);
        vec_t v;
        longint off;
        bit mapped;
        int idx;
        off = longint'(a) - longint'(BASE);
        mapped = (off >= 0) && (off / 4096 < NS);
        idx = mapped ? int'(off / 4096) : 0;
        v = '{wr, a, wd, st, w, slverr, rd, 0, 1'b0, 32'h0, 5'h0};
        v.lat  = mapped ? 2 + w : 1;
        v.err  = !mapped || slverr;
        v.erd  = (mapped && !wr) ? rd : 32'h0;
        v.psel = mapped ? 5'(1 << idx) : 5'h0;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [31:0] ra;
        tbl[0] = '{1'b1, 32'h1000_2010, 32'hA5A5_0001, 4'b0011, 0, 1'b0, 32'h1111_1111, 2, 1'b0, 32'h0, 5'b00100};
        tbl[1] = '{1'b0, 32'h1000_4000, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 5, 1'b0, 32'hDEAD_BEEF, 5'b10000};
        tbl[2] = '{1'b0, 32'h1000_5000, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1, 1'b1, 32'h0, 5'b00000};
        tbl[3] = '{1'b1, 32'h1000_1004, 32'h0BAD_0001, 4'hF, 0, 1'b1, 32'h2222_2222, 2, 1'b1, 32'h0, 5'b00010};
        tbl[4] = '{1'b0, 32'h1000_0FFC, 32'h0, 4'h0, 1, 1'b0, 32'h0123_4567, 3, 1'b0, 32'h0123_4567, 5'b00001};
        tbl[5] = '{1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1, 1'b1, 32'h0, 5'b00000};
        tbl[6] = '{1'b0, 32'h1000_3ABC, 32'h0, 4'h0, 2, 1'b1, 32'hCAFE_F00D, 4, 1'b1, 32'hCAFE_F00D, 5'b01000};
        tbl[7] = '{1'b1, 32'hFFFF_FFF0, 32'h7777_7777, 4'hC, 0, 1'b0, 32'h0, 1, 1'b1, 32'h0, 5'b00000};

        PRESET = 1'b1;
        bus.transfer = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0; bus.strb = '0;
        bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR = '0;
        #3;
        chk("reset.ctrl", {bus.PSEL, bus.PENABLE, bus.ready, bus.error, bus.PWRITE}, 64'h0);
        chk("reset.data", {bus.PADDR, bus.rdata}, 64'h0);
        chk("reset.wr",   {bus.PWDATA, bus.PSTRB}, 64'h0);
        @(posedge PCLK);
        #2 PRESET = 1'b0;
        @(posedge PCLK);
        #1;

        // Back-to-back table: each transfer starts the cycle after the previous ready.
        for (int i = 0; i < 8; i++) run($sformatf("vec%0d", i), tbl[i]);

`ifdef APB_TIMEOUT_EN
        v = '{1'b0, 32'h1000_0000, 32'h0, 4'h0, 1000, 1'b0, 32'h5555_AAAA, 6, 1'b1, 32'h0, 5'b00001};
        run("timeout", v);
        #4;
        chk("timeout.after", {bus.PSEL, bus.PENABLE, bus.ready}, 64'h0);
        @(posedge PCLK);
        #1;
`else
        v = '{1'b0, 32'h1000_0000, 32'h0, 4'h0, 10, 1'b0, 32'h5555_AAAA, 12, 1'b0, 32'h5555_AAAA, 5'b00001};
        run("longwait", v);
`endif

        // Asynchronous reset in the middle of ACCESS.
        bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_3000; bus.strb = 4'h0;
        bus.PREADY = '0;
        @(posedge PCLK); #1 bus.transfer = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        chk("prereset.access", {bus.PSEL, bus.PENABLE, bus.ready}, {5'b01000, 1'b1, 1'b0});
        #2 PRESET = 1'b1;
        bus.PREADY = '1;
        #1;
        chk("midreset.ctrl", {bus.PSEL, bus.PENABLE, bus.ready, bus.error}, 64'h0);
        chk("midreset.data", {bus.PADDR, bus.rdata}, 64'h0);
        @(posedge PCLK); #1;
        chk("midreset.noready", bus.ready, 1'b0);
        #3 PRESET = 1'b0;
        bus.PREADY = '0;
        @(posedge PCLK); #1;
        run("postreset", tbl[0]);

        // Randomised transfers against the address-map model.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = BASE - 32'($urandom_range(1, 64));
                default: ra = BASE + 32'($urandom_range(0, NS * 4096 - 1));
            endcase
            v = model(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom);
            run($sformatf("rnd%0d", n), v);
        end

        bus.transfer = 1'b0;
        @(posedge PCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
